// File: rtl/mem_arbiter.sv
// N-channel memory arbiter and bus controller: grants one requester at a time, drives the shared
// bus from latched request fields and returns a one-cycle response with an optional timeout error.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_CH     = 2,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH-1:0]              req_valid,
  input  logic [N_CH-1:0]              req_write,
  input  logic [N_CH*ADDR_W-1:0]       req_addr,
  input  logic [N_CH*DATA_W-1:0]       req_wdata,
  input  logic [N_CH*(DATA_W/8)-1:0]   req_sel,
  output logic [N_CH-1:0]              req_ready,
  output logic [N_CH-1:0]              rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [DATA_W-1:0]            bus_wdata,
  output logic [DATA_W/8-1:0]          bus_sel,
  output logic                         bus_read,
  output logic                         bus_write,
  input  logic                         bus_busy,
  input  logic [DATA_W-1:0]            bus_rdata,
  output logic [1:0]                   state
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
  localparam bit RoundRobin = (ARB_MODE == 1) && (N_CH > 1);

  typedef enum logic [1:0] {StIdle = 2'd0, StAccess = 2'd1, StResp = 2'd2} state_e;

  state_e              state_q;
  logic [CH_W-1:0]     ptr_q, gnt_q, gnt_idx;
  logic                gnt_any;
  logic                write_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [SEL_W-1:0]    sel_q;
  logic [CNT_W-1:0]    wait_q;

  // Search starts at ptr in round-robin mode, at channel 0 otherwise.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      idx = (RoundRobin ? int'(ptr_q) : 0) + k;
      if (idx >= int'(N_CH)) idx = idx - int'(N_CH);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == StIdle && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == StResp) rsp_valid[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt_any) begin
            addr_q  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[gnt_idx*DATA_W +: DATA_W];
            sel_q   <= req_sel[gnt_idx*SEL_W +: SEL_W];
            write_q <= req_write[gnt_idx];
            gnt_q   <= gnt_idx;
            err_q   <= 1'b0;
            wait_q  <= '0;
            if (RoundRobin) begin
              ptr_q <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
            end
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (!bus_busy) begin
            if (!write_q) rdata_q <= bus_rdata;
            err_q   <= 1'b0;
            state_q <= StResp;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
            // This busy edge is the WAIT_MAX-th one: abort without touching read data.
            if (WAIT_MAX != 0 && wait_q == CntLast) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end
          end
        end
        StResp: begin
          wait_q  <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_sel   = sel_q;
  assign bus_read  = (state_q == StAccess) && !write_q;
  assign bus_write = (state_q == StAccess) && write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = (state_q == StResp) && err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a cycle table on a fixed-priority instance, then hand sequences for
// round-robin, timeout and mid-transaction reset on a round-robin, WAIT_MAX=4 instance.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_sel;
  logic        bus_busy = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic [1:0]  d0_rdy, d0_rv, d0_st, d1_rdy, d1_rv, d1_st;
  logic [31:0] d0_rrd, d0_addr, d0_wdata, d1_rrd, d1_addr, d1_wdata;
  logic [3:0]  d0_sel, d1_sel;
  logic        d0_err, d0_rd, d0_wr, d1_err, d1_rd, d1_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign req_addr  = {32'h0000_0040, 32'h0000_0100};
  assign req_wdata = {32'h1234_5678, 32'hAAAA_5555};
  assign req_sel   = {4'b0011, 4'b1111};

  mem_arbiter #(.ARB_MODE(0), .WAIT_MAX(16)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_sel(req_sel), .req_ready(d0_rdy), .rsp_valid(d0_rv),
    .rsp_rdata(d0_rrd), .rsp_err(d0_err), .bus_addr(d0_addr), .bus_wdata(d0_wdata),
    .bus_sel(d0_sel), .bus_read(d0_rd), .bus_write(d0_wr), .bus_busy(bus_busy),
    .bus_rdata(bus_rdata), .state(d0_st)
  );

  mem_arbiter #(.ARB_MODE(1), .WAIT_MAX(4)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_sel(req_sel), .req_ready(d1_rdy), .rsp_valid(d1_rv),
    .rsp_rdata(d1_rrd), .rsp_err(d1_err), .bus_addr(d1_addr), .bus_wdata(d1_wdata),
    .bus_sel(d1_sel), .bus_read(d1_rd), .bus_write(d1_wr), .bus_busy(bus_busy),
    .bus_rdata(bus_rdata), .state(d1_st)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  vld, wr;
    logic        busy;
    logic [31:0] rdata;
    logic [1:0]  rdy, rv;
    logic        rd, wrs;
    logic [1:0]  st;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] rrd;
    logic        err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] v, input logic [1:0] w, input logic b,
                     input logic [31:0] rdat, input logic [1:0] rdy, input logic [1:0] rv,
                     input logic rd, input logic wrs, input logic [1:0] st,
                     input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                     input logic [31:0] rrd, input logic e);
    vec_t x;
    x.rst = r; x.vld = v; x.wr = w; x.busy = b; x.rdata = rdat; x.rdy = rdy; x.rv = rv;
    x.rd = rd; x.wrs = wrs; x.st = st; x.addr = a; x.wdata = wd; x.sel = s; x.rrd = rrd;
    x.err = e;
    vt.push_back(x);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst vld wr busy rdata | rdy rv rd wr st addr wdata sel rrd err
    add(1, 2'b11, 2'b00, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2'b11, 2'b00, 0, 0,            2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2'b00, 2'b00, 0, 32'hDEADBEEF, 2'b00, 2'b00, 1, 0, 1, 32'h100, 32'hAAAA5555, 4'hF, 0, 0);
    add(0, 2'b00, 2'b00, 0, 0,            2'b00, 2'b01, 0, 0, 2, 32'h100, 32'hAAAA5555, 4'hF,
        32'hDEADBEEF, 0);
    add(0, 2'b10, 2'b10, 0, 0,            2'b10, 2'b00, 0, 0, 0, 32'h100, 32'hAAAA5555, 4'hF,
        32'hDEADBEEF, 0);
    add(0, 2'b00, 2'b00, 0, 32'hCAFEF00D, 2'b00, 2'b00, 0, 1, 1, 32'h40, 32'h12345678, 4'h3,
        32'hDEADBEEF, 0);
    add(0, 2'b00, 2'b00, 0, 0,            2'b00, 2'b10, 0, 0, 2, 32'h40, 32'h12345678, 4'h3,
        32'hDEADBEEF, 0);
    add(0, 2'b11, 2'b00, 0, 0,            2'b01, 2'b00, 0, 0, 0, 32'h40, 32'h12345678, 4'h3,
        32'hDEADBEEF, 0);
    add(0, 2'b11, 2'b00, 0, 32'h11111111, 2'b00, 2'b00, 1, 0, 1, 32'h100, 32'hAAAA5555, 4'hF,
        32'hDEADBEEF, 0);
    add(0, 2'b11, 2'b00, 0, 0,            2'b00, 2'b01, 0, 0, 2, 32'h100, 32'hAAAA5555, 4'hF,
        32'h11111111, 0);
    add(0, 2'b11, 2'b00, 0, 0,            2'b01, 2'b00, 0, 0, 0, 32'h100, 32'hAAAA5555, 4'hF,
        32'h11111111, 0);
    for (int i = 0; i < 3; i++)
      add(0, 2'b00, 2'b00, 1, 0,          2'b00, 2'b00, 1, 0, 1, 32'h100, 32'hAAAA5555, 4'hF,
          32'h11111111, 0);
    add(0, 2'b00, 2'b00, 0, 32'h22222222, 2'b00, 2'b00, 1, 0, 1, 32'h100, 32'hAAAA5555, 4'hF,
        32'h11111111, 0);
    add(0, 2'b00, 2'b00, 0, 0,            2'b00, 2'b01, 0, 0, 2, 32'h100, 32'hAAAA5555, 4'hF,
        32'h22222222, 0);
    add(0, 2'b00, 2'b00, 0, 0,            2'b00, 2'b00, 0, 0, 0, 32'h100, 32'hAAAA5555, 4'hF,
        32'h22222222, 0);

    #1;
    foreach (vt[i]) begin
      rst = vt[i].rst; req_valid = vt[i].vld; req_write = vt[i].wr;
      bus_busy = vt[i].busy; bus_rdata = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d req_ready", i), 32'(d0_rdy), 32'(vt[i].rdy));
      chk($sformatf("v%0d rsp_valid", i), 32'(d0_rv), 32'(vt[i].rv));
      chk($sformatf("v%0d bus_read", i), 32'(d0_rd), 32'(vt[i].rd));
      chk($sformatf("v%0d bus_write", i), 32'(d0_wr), 32'(vt[i].wrs));
      chk($sformatf("v%0d state", i), 32'(d0_st), 32'(vt[i].st));
      chk($sformatf("v%0d bus_addr", i), d0_addr, vt[i].addr);
      chk($sformatf("v%0d bus_wdata", i), d0_wdata, vt[i].wdata);
      chk($sformatf("v%0d bus_sel", i), 32'(d0_sel), 32'(vt[i].sel));
      chk($sformatf("v%0d rsp_rdata", i), d0_rrd, vt[i].rrd);
      chk($sformatf("v%0d rsp_err", i), 32'(d0_err), 32'(vt[i].err));
      next_cycle();
    end

    // Asynchronous reset in the middle of a write access: strobe drops at once, no response.
    req_valid = 2'b01; req_write = 2'b01; bus_busy = 1'b1;
    @(negedge clk);
    chk("rstmid accept", 32'(d0_rdy), 32'h1);
    next_cycle();
    req_valid = 2'b00;
    chk("rstmid bus_write before", 32'(d0_wr), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid bus_write d0", 32'(d0_wr), 32'h0);
    chk("rstmid bus_write d1", 32'(d1_wr), 32'h0);
    chk("rstmid state d0", 32'(d0_st), 32'h0);
    chk("rstmid req_ready", 32'(d0_rdy), 32'h0);
    next_cycle();
    rst = 1'b0; bus_busy = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("rstmid c%0d rsp_valid d0", n), 32'(d0_rv), 32'h0);
      chk($sformatf("rstmid c%0d rsp_valid d1", n), 32'(d1_rv), 32'h0);
      next_cycle();
    end

    // Continuous contention: fixed priority starves channel 1, round-robin alternates.
    req_valid = 2'b11; req_write = 2'b00; bus_rdata = 32'h0000_00A5;
    for (int n = 0; n < 12; n++) begin
      if (n >= 10) req_valid = 2'b00;
      @(negedge clk);
      if (n % 3 == 0) begin
        chk($sformatf("rr g%0d ready d1", n / 3), 32'(d1_rdy), ((n / 3) % 2 == 0) ? 32'h1 : 32'h2);
        chk($sformatf("fp g%0d ready d0", n / 3), 32'(d0_rdy), 32'h1);
      end else if (n % 3 == 2) begin
        chk($sformatf("rr g%0d rsp d1", n / 3), 32'(d1_rv), ((n / 3) % 2 == 0) ? 32'h1 : 32'h2);
        chk($sformatf("fp g%0d rsp d0", n / 3), 32'(d0_rv), 32'h1);
      end
      next_cycle();
    end

    // Timeout on the WAIT_MAX=4 instance; the WAIT_MAX=16 instance keeps waiting.
    req_valid = 2'b01; bus_busy = 1'b1;
    @(negedge clk);
    chk("to accept d1", 32'(d1_rdy), 32'h1);
    next_cycle();
    req_valid = 2'b00;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk($sformatf("to c%0d state d1", n), 32'(d1_st), 32'h1);
      chk($sformatf("to c%0d bus_read d1", n), 32'(d1_rd), 32'h1);
      chk($sformatf("to c%0d bus_addr d1", n), d1_addr, 32'h100);
      next_cycle();
    end
    @(negedge clk);
    chk("to rsp_valid d1", 32'(d1_rv), 32'h1);
    chk("to rsp_err d1", 32'(d1_err), 32'h1);
    chk("to rsp_rdata d1", d1_rrd, 32'h0000_00A5);
    chk("to still waiting d0", 32'(d0_st), 32'h1);
    chk("to no rsp d0", 32'(d0_rv), 32'h0);
    next_cycle();
    req_valid = 2'b01; bus_busy = 1'b0; bus_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("after to idle d1", 32'(d1_st), 32'h0);
    chk("after to accept d1", 32'(d1_rdy), 32'h1);
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    chk("after to bus_read d1", 32'(d1_rd), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("after to rsp_valid d1", 32'(d1_rv), 32'h1);
    chk("after to rsp_err d1", 32'(d1_err), 32'h0);
    chk("after to rsp_rdata d1", d1_rrd, 32'h5A5A_5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
